// File: rtl/multicycle_ctrl_hs_if.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_hs_if
// Control bundle between the multi-cycle controller and the accumulator/stack
// datapath plus its memory port.
//   master : controller side (reads opcode/flags/mem_ready, drives controls)
//   slave  : datapath/memory side (drives opcode/flags/mem_ready, reads controls)
// Signals:
//   op[OPW], ir_1[4], ir_2[2], cc      instruction fields and condition flag
//   mem_ready                          memory completes current access
//   T_mdr,T_label,T_pc,T_sp,T_reg      bus driver enables
//   LD_mar,LD_mdr,LD_y,LD_ir,LD_pc,LD_sp,LD_reg  register load enables
//   pc_inc,sp_inc,sp_dec               incrementer strobes
//   alu_on, fn_select[FNW]             ALU enable and function
//   mem_req, mem_we                    memory request, 1=write
//   state[5], halted, illegal, bus_err status
// ----------------------------------------------------------------------------
interface multicycle_ctrl_hs_if #(
    parameter int unsigned OPW = 4,
    parameter int unsigned FNW = 3
);
    logic [OPW-1:0] op;
    logic [3:0]     ir_1;
    logic [1:0]     ir_2;
    logic           cc;
    logic           mem_ready;

    logic           T_mdr;
    logic           T_label;
    logic           T_pc;
    logic           T_sp;
    logic           T_reg;
    logic           LD_mar;
    logic           LD_mdr;
    logic           LD_y;
    logic           LD_ir;
    logic           LD_pc;
    logic           LD_sp;
    logic           LD_reg;
    logic           pc_inc;
    logic           sp_inc;
    logic           sp_dec;
    logic           alu_on;
    logic [FNW-1:0] fn_select;
    logic           mem_req;
    logic           mem_we;
    logic [4:0]     state;
    logic           halted;
    logic           illegal;
    logic           bus_err;

    modport master (
        input  op, ir_1, ir_2, cc, mem_ready,
        output T_mdr, T_label, T_pc, T_sp, T_reg,
        output LD_mar, LD_mdr, LD_y, LD_ir, LD_pc, LD_sp, LD_reg,
        output pc_inc, sp_inc, sp_dec, alu_on, fn_select,
        output mem_req, mem_we, state, halted, illegal, bus_err
    );

    modport slave (
        output op, ir_1, ir_2, cc, mem_ready,
        input  T_mdr, T_label, T_pc, T_sp, T_reg,
        input  LD_mar, LD_mdr, LD_y, LD_ir, LD_pc, LD_sp, LD_reg,
        input  pc_inc, sp_inc, sp_dec, alu_on, fn_select,
        input  mem_req, mem_we, state, halted, illegal, bus_err
    );
endinterface

// File: rtl/multicycle_ctrl_hs.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_hs
// Multi-cycle FSM controller for the accumulator/stack datapath. Fetches,
// decodes and sequences ALU, LOAD, STORE, BR, CALL, RET and HALT instructions.
// Memory accesses use a req/ready handshake with unbounded wait states and an
// optional timeout into a sticky error state.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-low reset
//   bus  master modport of multicycle_ctrl_hs_if (instruction fields,
//        mem_ready in; datapath controls, memory request and status out)
// Controls are a decode of the state register; the read-data load strobe in
// wait states is additionally qualified by mem_ready so it fires only on the
// completing cycle.
// ----------------------------------------------------------------------------
module multicycle_ctrl_hs #(
    parameter int unsigned OPW     = 4,
    parameter int unsigned FNW     = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_ctrl_hs_if.master bus
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [OPW-1:0] OP_ALU   = OPW'(0);
    localparam logic [OPW-1:0] OP_LOAD  = OPW'(2);
    localparam logic [OPW-1:0] OP_STORE = OPW'(3);
    localparam logic [OPW-1:0] OP_BR    = OPW'(4);
    localparam logic [OPW-1:0] OP_CALL  = OPW'(6);
    localparam logic [OPW-1:0] OP_RET   = OPW'(7);
    localparam logic [OPW-1:0] OP_HALT  = {OPW{1'b1}};

    typedef enum logic [4:0] {
        ST_IDLE = 5'd0,
        ST_F0   = 5'd1,
        ST_F1   = 5'd2,
        ST_F2   = 5'd3,
        ST_DEC  = 5'd4,
        ST_A1   = 5'd5,
        ST_A2   = 5'd6,
        ST_L1   = 5'd7,
        ST_L2   = 5'd8,
        ST_L3   = 5'd9,
        ST_S1   = 5'd10,
        ST_S2   = 5'd11,
        ST_S3   = 5'd12,
        ST_B1   = 5'd13,
        ST_C1   = 5'd14,
        ST_C2   = 5'd15,
        ST_C3   = 5'd16,
        ST_C4   = 5'd17,
        ST_C5   = 5'd18,
        ST_R1   = 5'd19,
        ST_R2   = 5'd20,
        ST_R3   = 5'd21,
        ST_HALT = 5'd22,
        ST_ERR  = 5'd23
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_wait_cnt;

    logic [OPW-1:0]  w_op;
    logic [FNW-1:0]  w_fn;
    logic            w_mem_ready;
    logic            w_br_taken;
    logic            w_op_legal;
    logic            w_in_wait;
    logic            w_timeout;
    logic [3:0]      w_unused_ir1;

    // Datapath control decode
    logic            w_t_mdr, w_t_label, w_t_pc, w_t_sp, w_t_reg;
    logic            w_ld_mar, w_ld_mdr, w_ld_y, w_ld_ir, w_ld_pc, w_ld_sp, w_ld_reg;
    logic            w_pc_inc, w_sp_inc, w_sp_dec, w_alu_on;
    logic [FNW-1:0]  w_fn_select;
    logic            w_mem_req, w_mem_we, w_halted, w_illegal, w_bus_err;

    assign w_op         = bus.op;
    assign w_fn         = bus.ir_1[FNW-1:0];
    assign w_unused_ir1 = bus.ir_1;
    assign w_mem_ready  = bus.mem_ready;

    // Branch taken when unconditional (mode 00) or the condition flag is set
    assign w_br_taken = (bus.ir_2 == 2'b00) || bus.cc;

    assign w_op_legal = (w_op == OP_ALU)  || (w_op == OP_LOAD) ||
                        (w_op == OP_STORE) || (w_op == OP_BR)   ||
                        (w_op == OP_CALL) || (w_op == OP_RET)  ||
                        (w_op == OP_HALT);

    // States that hold a memory request open until mem_ready
    assign w_in_wait = (r_state == ST_F1) || (r_state == ST_L2) ||
                       (r_state == ST_S3) || (r_state == ST_C4) ||
                       (r_state == ST_R2);

    // Expiry on the TIMEOUT-th consecutive low cycle; a ready in that cycle wins
    assign w_timeout = (TIMEOUT != 0) && w_in_wait && !w_mem_ready &&
                       (r_wait_cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Wait counter: counts low-ready cycles inside a wait state, zero elsewhere
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
        end else if (w_in_wait && !w_mem_ready) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_F0;
            ST_F0:   w_state_nxt = ST_F1;
            ST_F1:   if (w_mem_ready) w_state_nxt = ST_F2;
            ST_F2:   w_state_nxt = ST_DEC;
            ST_DEC: begin
                if (w_op == OP_HALT)       w_state_nxt = ST_HALT;
                else if (w_op == OP_ALU)   w_state_nxt = ST_A1;
                else if (w_op == OP_LOAD)  w_state_nxt = ST_L1;
                else if (w_op == OP_STORE) w_state_nxt = ST_S1;
                else if (w_op == OP_BR)    w_state_nxt = w_br_taken ? ST_B1 : ST_F0;
                else if (w_op == OP_CALL)  w_state_nxt = ST_C1;
                else if (w_op == OP_RET)   w_state_nxt = ST_R1;
                else                       w_state_nxt = ST_F0;
            end
            ST_A1:   w_state_nxt = ST_A2;
            ST_A2:   w_state_nxt = ST_F0;
            ST_L1:   w_state_nxt = ST_L2;
            ST_L2:   if (w_mem_ready) w_state_nxt = ST_L3;
            ST_L3:   w_state_nxt = ST_F0;
            ST_S1:   w_state_nxt = ST_S2;
            ST_S2:   w_state_nxt = ST_S3;
            ST_S3:   if (w_mem_ready) w_state_nxt = ST_F0;
            ST_B1:   w_state_nxt = ST_F0;
            ST_C1:   w_state_nxt = ST_C2;
            ST_C2:   w_state_nxt = ST_C3;
            ST_C3:   w_state_nxt = ST_C4;
            ST_C4:   if (w_mem_ready) w_state_nxt = ST_C5;
            ST_C5:   w_state_nxt = ST_F0;
            ST_R1:   w_state_nxt = ST_R2;
            ST_R2:   if (w_mem_ready) w_state_nxt = ST_R3;
            ST_R3:   w_state_nxt = ST_F0;
            ST_HALT: w_state_nxt = ST_HALT;
            ST_ERR:  w_state_nxt = ST_ERR;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = ST_ERR;
        end
    end

    // Control decode of the current state
    always_comb begin
        w_t_mdr     = 1'b0;
        w_t_label   = 1'b0;
        w_t_pc      = 1'b0;
        w_t_sp      = 1'b0;
        w_t_reg     = 1'b0;
        w_ld_mar    = 1'b0;
        w_ld_mdr    = 1'b0;
        w_ld_y      = 1'b0;
        w_ld_ir     = 1'b0;
        w_ld_pc     = 1'b0;
        w_ld_sp     = 1'b0;
        w_ld_reg    = 1'b0;
        w_pc_inc    = 1'b0;
        w_sp_inc    = 1'b0;
        w_sp_dec    = 1'b0;
        w_alu_on    = 1'b0;
        w_fn_select = '0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_halted    = 1'b0;
        w_illegal   = 1'b0;
        w_bus_err   = 1'b0;
        case (r_state)
            ST_F0: begin
                w_t_pc   = 1'b1;
                w_ld_mar = 1'b1;
            end
            ST_F1, ST_L2, ST_R2: begin
                w_mem_req = 1'b1;
                w_ld_mdr  = w_mem_ready;
            end
            ST_F2: begin
                w_t_mdr  = 1'b1;
                w_ld_ir  = 1'b1;
                w_pc_inc = 1'b1;
            end
            ST_DEC: begin
                w_illegal = !w_op_legal;
            end
            ST_A1: begin
                w_t_reg = 1'b1;
                w_ld_y  = 1'b1;
            end
            ST_A2: begin
                w_t_reg     = 1'b1;
                w_alu_on    = 1'b1;
                w_fn_select = w_fn;
                w_ld_reg    = 1'b1;
            end
            ST_L1, ST_S1: begin
                w_t_label = 1'b1;
                w_ld_mar  = 1'b1;
            end
            ST_L3: begin
                w_t_mdr  = 1'b1;
                w_ld_reg = 1'b1;
            end
            ST_S2: begin
                w_t_reg  = 1'b1;
                w_ld_mdr = 1'b1;
            end
            ST_S3, ST_C4: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
            end
            ST_B1, ST_C5: begin
                w_t_label = 1'b1;
                w_ld_pc   = 1'b1;
            end
            ST_C1: begin
                w_sp_dec = 1'b1;
            end
            ST_C2, ST_R1: begin
                w_t_sp   = 1'b1;
                w_ld_mar = 1'b1;
            end
            ST_C3: begin
                w_t_pc   = 1'b1;
                w_ld_mdr = 1'b1;
            end
            ST_R3: begin
                w_t_mdr  = 1'b1;
                w_ld_pc  = 1'b1;
                w_sp_inc = 1'b1;
            end
            ST_HALT: begin
                w_halted = 1'b1;
            end
            ST_ERR: begin
                w_bus_err = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.T_mdr     = w_t_mdr;
    assign bus.T_label   = w_t_label;
    assign bus.T_pc      = w_t_pc;
    assign bus.T_sp      = w_t_sp;
    assign bus.T_reg     = w_t_reg;
    assign bus.LD_mar    = w_ld_mar;
    assign bus.LD_mdr    = w_ld_mdr;
    assign bus.LD_y      = w_ld_y;
    assign bus.LD_ir     = w_ld_ir;
    assign bus.LD_pc     = w_ld_pc;
    assign bus.LD_sp     = w_ld_sp;
    assign bus.LD_reg    = w_ld_reg;
    assign bus.pc_inc    = w_pc_inc;
    assign bus.sp_inc    = w_sp_inc;
    assign bus.sp_dec    = w_sp_dec;
    assign bus.alu_on    = w_alu_on;
    assign bus.fn_select = w_fn_select;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.state     = 5'(r_state);
    assign bus.halted    = w_halted;
    assign bus.illegal   = w_illegal;
    assign bus.bus_err   = w_bus_err;

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl_hs
// Self-checking bench: each instruction is expanded into its list of
// micro-steps (named control sets), wait steps are stretched by a random or
// directed number of not-ready cycles, and every cycle's full control vector
// is compared against the expectation.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl_hs;

    localparam int unsigned OPW     = 4;
    localparam int unsigned FNW     = 3;
    localparam int unsigned TIMEOUT = 15;

    // Control vector bit positions
    localparam logic [23:0] X_TMDR   = 24'(1) << 0;
    localparam logic [23:0] X_TLABEL = 24'(1) << 1;
    localparam logic [23:0] X_TPC    = 24'(1) << 2;
    localparam logic [23:0] X_TSP    = 24'(1) << 3;
    localparam logic [23:0] X_TREG   = 24'(1) << 4;
    localparam logic [23:0] X_LDMAR  = 24'(1) << 5;
    localparam logic [23:0] X_LDMDR  = 24'(1) << 6;
    localparam logic [23:0] X_LDY    = 24'(1) << 7;
    localparam logic [23:0] X_LDIR   = 24'(1) << 8;
    localparam logic [23:0] X_LDPC   = 24'(1) << 9;
    localparam logic [23:0] X_LDREG  = 24'(1) << 11;
    localparam logic [23:0] X_PCINC  = 24'(1) << 12;
    localparam logic [23:0] X_SPINC  = 24'(1) << 13;
    localparam logic [23:0] X_SPDEC  = 24'(1) << 14;
    localparam logic [23:0] X_ALUON  = 24'(1) << 15;
    localparam logic [23:0] X_MREQ   = 24'(1) << 16;
    localparam logic [23:0] X_MWE    = 24'(1) << 17;
    localparam logic [23:0] X_HALT   = 24'(1) << 18;
    localparam logic [23:0] X_ILL    = 24'(1) << 19;
    localparam logic [23:0] X_BERR   = 24'(1) << 20;

    typedef struct packed {
        logic [23:0] sig;
        logic        wt;
        logic        rd;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    multicycle_ctrl_hs_if #(.OPW(OPW), .FNW(FNW)) bus ();

    multicycle_ctrl_hs #(
        .OPW     (OPW),
        .FNW     (FNW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [23:0] w_act;
    assign w_act = {bus.fn_select, bus.bus_err, bus.illegal, bus.halted,
                    bus.mem_we, bus.mem_req, bus.alu_on, bus.sp_dec,
                    bus.sp_inc, bus.pc_inc, bus.LD_reg, bus.LD_sp, bus.LD_pc,
                    bus.LD_ir, bus.LD_y, bus.LD_mdr, bus.LD_mar, bus.T_reg,
                    bus.T_sp, bus.T_pc, bus.T_label, bus.T_mdr};

    task automatic check_eq(input string tag, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One cycle: called at a negedge, drives mem_ready, checks, moves to next negedge
    task automatic cyc(input string tag, input logic mr, input logic [23:0] exp);
        bus.mem_ready = mr;
        #1;
        check_eq(tag, w_act, exp);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check_eq({tag, ".rst_async"}, w_act, 24'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc({tag, ".idle"}, 1'($urandom_range(0, 1)), 24'h0);
    endtask

    // Memory wait step: k not-ready cycles, then one ready cycle unless timed out
    task automatic wait_step(input string tag, input logic [23:0] sig, input logic rd,
                             input int k, output bit err);
        err = 1'b0;
        for (int i = 0; i <= k && !err; i++) begin
            if (TIMEOUT != 0 && i == int'(TIMEOUT)) err = 1'b1;
            else if (i < k) cyc(tag, 1'b0, sig);
            else            cyc(tag, 1'b1, rd ? (sig | X_LDMDR) : sig);
        end
    endtask

    // Runs one instruction from F0; kf/kx are fetch/execute not-ready counts
    task automatic run_instr(input string name, input logic [3:0] opv, input logic [3:0] ir1,
                             input logic [1:0] ir2, input logic ccv, input int kf, input int kx);
        step_t q[$];
        bit    term;
        bit    legal;
        term = 1'b0;
        legal = (opv == 4'd0) || (opv == 4'd2) || (opv == 4'd3) || (opv == 4'd4) ||
                (opv == 4'd6) || (opv == 4'd7) || (opv == 4'hF);
        bus.op = opv;
        bus.ir_1 = ir1;
        bus.ir_2 = ir2;
        bus.cc = ccv;
        q.push_back('{X_TPC | X_LDMAR, 1'b0, 1'b0});
        q.push_back('{X_MREQ, 1'b1, 1'b1});
        q.push_back('{X_TMDR | X_LDIR | X_PCINC, 1'b0, 1'b0});
        q.push_back('{legal ? 24'h0 : X_ILL, 1'b0, 1'b0});
        case (opv)
            4'd0: begin
                q.push_back('{X_TREG | X_LDY, 1'b0, 1'b0});
                q.push_back('{X_TREG | X_ALUON | X_LDREG | (24'(ir1[FNW-1:0]) << 21), 1'b0, 1'b0});
            end
            4'd2: begin
                q.push_back('{X_TLABEL | X_LDMAR, 1'b0, 1'b0});
                q.push_back('{X_MREQ, 1'b1, 1'b1});
                q.push_back('{X_TMDR | X_LDREG, 1'b0, 1'b0});
            end
            4'd3: begin
                q.push_back('{X_TLABEL | X_LDMAR, 1'b0, 1'b0});
                q.push_back('{X_TREG | X_LDMDR, 1'b0, 1'b0});
                q.push_back('{X_MREQ | X_MWE, 1'b1, 1'b0});
            end
            4'd4: begin
                if (ir2 == 2'b00 || ccv) q.push_back('{X_TLABEL | X_LDPC, 1'b0, 1'b0});
            end
            4'd6: begin
                q.push_back('{X_SPDEC, 1'b0, 1'b0});
                q.push_back('{X_TSP | X_LDMAR, 1'b0, 1'b0});
                q.push_back('{X_TPC | X_LDMDR, 1'b0, 1'b0});
                q.push_back('{X_MREQ | X_MWE, 1'b1, 1'b0});
                q.push_back('{X_TLABEL | X_LDPC, 1'b0, 1'b0});
            end
            4'd7: begin
                q.push_back('{X_TSP | X_LDMAR, 1'b0, 1'b0});
                q.push_back('{X_MREQ, 1'b1, 1'b1});
                q.push_back('{X_TMDR | X_LDPC | X_SPINC, 1'b0, 1'b0});
            end
            default: begin
            end
        endcase
        for (int i = 0; i < q.size() && !term; i++) begin
            string tag;
            tag = $sformatf("%s.op%0h.c%0d", name, opv, i);
            if (q[i].wt) wait_step(tag, q[i].sig, q[i].rd, (i == 1) ? kf : kx, term);
            else         cyc(tag, 1'($urandom_range(0, 1)), q[i].sig);
        end
        if (term) begin
            for (int i = 0; i < 3; i++) cyc({name, ".err"}, 1'($urandom_range(0, 1)), X_BERR);
            do_reset(name);
        end else if (opv == 4'hF) begin
            for (int i = 0; i < 4; i++) begin
                bus.op = 4'($urandom_range(0, 15));
                cyc({name, ".halt"}, 1'($urandom_range(0, 1)), X_HALT);
            end
            do_reset(name);
        end
    endtask

    function automatic int rand_wait(input int to_odds);
        if ($urandom_range(0, to_odds - 1) == 0) return 14 + int'($urandom_range(0, 2));
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        bus.op = '0;
        bus.ir_1 = '0;
        bus.ir_2 = '0;
        bus.cc = 1'b0;
        bus.mem_ready = 1'b1;
        #2;
        check_eq("reset", w_act, 24'h0);
        @(negedge clk);
        check_eq("reset_held", w_act, 24'h0);
        rst = 1'b1;
        cyc("idle", 1'b1, 24'h0);

        run_instr("alu",      4'd0, 4'b0101, 2'b00, 1'b0, 0, 0);
        run_instr("load_w3",  4'd2, 4'd0,    2'b00, 1'b0, 0, 3);
        run_instr("store_to", 4'd3, 4'd0,    2'b00, 1'b0, 0, 20);
        run_instr("store_14", 4'd3, 4'd0,    2'b00, 1'b0, 0, 14);
        run_instr("br_nt",    4'd4, 4'd0,    2'b01, 1'b0, 0, 0);
        run_instr("br_cc",    4'd4, 4'd0,    2'b01, 1'b1, 0, 0);
        run_instr("br_uncnd", 4'd4, 4'd0,    2'b00, 1'b0, 0, 0);
        run_instr("call",     4'd6, 4'd0,    2'b00, 1'b0, 0, 0);
        run_instr("ret",      4'd7, 4'd0,    2'b00, 1'b0, 0, 0);
        run_instr("illegal",  4'hA, 4'd0,    2'b00, 1'b0, 0, 0);
        run_instr("fetch_to", 4'd0, 4'd3,    2'b00, 1'b0, 15, 0);

        // Reset asserted in the middle of a fetch wait
        bus.op = 4'd0;
        cyc("midrst.f0", 1'b1, X_TPC | X_LDMAR);
        bus.mem_ready = 1'b0;
        #1;
        check_eq("midrst.f1", w_act, X_MREQ);
        do_reset("midrst");

        run_instr("halt",     4'hF, 4'd0,    2'b00, 1'b0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            run_instr("rnd", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      rand_wait(40), rand_wait(12));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
